icache_line_refill: RTL and testbench
=====================================

// Module: icache_line_refill
// PURPOSE
//  Memory-side refill engine for the I-cache line store. On a miss it issues one line-aligned
//  burst read, accepts BEATS data beats with a valid/ready handshake and assembles them into a
//  LINE_W line. It then drives a single write (enable=1, read=0) into the line store.
//  The requested (critical) word is forwarded to the fetch stage as soon as it arrives.
// PARAMETERS
//  ADDR_W  32   byte address width
//  LINE_W  256  line width in bits (32 B line, offset = addr[4:0])
//  BEAT_W  32   memory data beat width; BEATS = LINE_W/BEAT_W = 8 (localparam)
// PORTS
//  clk              in   1       clock; all logic posedge
//  rst              in   1       reset, synchronous, active-high
//  miss_valid       in   1       refill request from fetch
//  miss_addr        in   ADDR_W  missing byte address
//  miss_ready       out  1       high only in IDLE
//  mem_req_valid    out  1       burst read request
//  mem_req_ready    in   1       memory accepts request
//  mem_req_addr     out  ADDR_W  {miss_addr[31:5],5'b0}
//  mem_req_len      out  4       BEATS-1 (constant 7)
//  mem_rdata_valid  in   1       beat valid
//  mem_rdata        in   BEAT_W  beat data, ascending word order
//  mem_rdata_last   in   1       marks final beat
//  mem_rdata_err    in   1       bus error on this beat
//  mem_rdata_ready  out  1       high only in BEAT state
//  line_enable      out  1       line store enable (1-cycle pulse)
//  line_read        out  1       0 during fill write, else 1
//  line_compare     out  1       constant 0 (refill writes never compare)
//  line_address     out  ADDR_W  line-aligned address of the fill
//  line_data        out  LINE_W  assembled line
//  crit_valid       out  1       1-cycle pulse: critical word available
//  crit_word        out  BEAT_W  critical word
//  refill_done      out  1       1-cycle pulse: line written
//  refill_err       out  1       1-cycle pulse: refill aborted
//  busy             out  1       not IDLE
// BEHAVIOUR
//  Reset: state=IDLE, beat_cnt=0, crit_done=0; all outputs 0 except line_read=1, miss_ready=1.
//  FSM: IDLE -> REQ on miss_valid (latch addr, clear beat_cnt/crit_done).
//   REQ: mem_req_valid=1, addr/len stable until mem_req_ready; REQ -> BEAT on handshake.
//   BEAT: beat accepted when mem_rdata_valid & mem_rdata_ready; word k -> line bits [32k+31:32k];
//    beat_cnt increments (3 bits).
//    If k == miss_addr[4:2], crit_valid=1 and crit_word=beat the next cycle (only once per refill).
//    err beat -> ERR. last on beat k<7, or k==7 without last -> ERR (protocol error).
//    Beat 7 with last and no err -> FILL.
//   FILL (1 cycle): line_enable=1, line_read=0, line_compare=0, line_address/line_data valid.
//    -> DONE.
//   DONE (1 cycle): refill_done=1 -> IDLE.
//   ERR (1 cycle): refill_err=1, no line write, partial line discarded -> IDLE.
//  Latency: mem_req_ready in cycle t, beats back-to-back from t+1 -> line write at t+9,
//   refill_done at t+10, next miss_ready at t+11.
//  miss_valid while busy is ignored (miss_ready=0). Gaps between beats are legal.
//  rst mid-refill: immediate IDLE next cycle, no line write/done/err pulse.
//  Beats arriving outside BEAT are not accepted (ready=0).
//  line_data holds last assembled value outside FILL; consumers sample only on line_enable.
// STRUCTURE
//  Shared pkg icache_pkg: LINE_W, BEAT_W, BEATS, OFFSET_W=5, word-index width=3,
//   refill state enum {IDLE,REQ,BEAT,FILL,DONE,ERR}.
//  One sub-module natural: icache_line_assembler (beat shift-in to LINE_W, word index decode,
//   critical-word match); FSM and handshakes stay in this module.
// TESTING
//  1 miss_addr=0x0000_1234, ready immediate, beats 0..7 = 0xA0..0xA7 -> req_addr 0x0000_1220,
//    crit_word=0xA5 after beat 5, line_data[191:160]=0xA5, line_enable one cycle, done next.
//  2 Same with 2-cycle gaps between beats and mem_req_ready delayed 3 cycles
//    -> identical line, req fields stable while waiting, done only after beat 7.
//  3 mem_rdata_err on beat 3 -> refill_err pulse, line_enable never asserted, miss_ready returns.
//  4 mem_rdata_last on beat 5 -> ERR, no write; and beat 7 without last -> ERR.
//  5 rst asserted during beat 4 -> IDLE next cycle, no pulses; new miss then completes normally.
//  6 miss_valid held high through refill -> exactly one mem request per refill;
//    miss_addr offset 0x00 gives crit on beat 0, offset 0x1C on beat 7.

Source files
------------

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared constants and refill state encoding for the I-cache refill engine
package icache_pkg;

  localparam int LINE_W     = 256;
  localparam int BEAT_W     = 32;
  localparam int BEATS      = LINE_W / BEAT_W;
  localparam int OFFSET_W   = 5;
  localparam int WORD_IDX_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    BEAT,
    FILL,
    DONE,
    ERR
  } refill_state_e;

endpackage

// File: rtl/icache_line_assembler.sv
// rtl/icache_line_assembler.sv - shifts memory beats into a line and forwards the critical word
module icache_line_assembler #(
  parameter int LINE_W = 256,
  parameter int BEAT_W = 32,
  parameter int IDX_W  = $clog2(LINE_W / BEAT_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              beat_fire_i,
  input  logic              beat_err_i,
  input  logic [IDX_W-1:0]  beat_idx_i,
  input  logic [BEAT_W-1:0] beat_data_i,
  input  logic [IDX_W-1:0]  crit_idx_i,
  output logic [LINE_W-1:0] line_o,
  output logic              crit_valid_o,
  output logic [BEAT_W-1:0] crit_word_o
);
  import icache_pkg::*;

  localparam int NBEATS = LINE_W / BEAT_W;

  logic [LINE_W-1:0] line_q, line_d;
  logic              crit_done_q, crit_done_d;
  logic              crit_valid_q, crit_valid_d;
  logic [BEAT_W-1:0] crit_word_q, crit_word_d;
  logic              crit_hit;

  // A poisoned beat never counts as the critical word; fetch must not see bad data.
  assign crit_hit = beat_fire_i && !beat_err_i && !crit_done_q && (beat_idx_i == crit_idx_i);

  // Decode the beat index into its word slot; untouched slots keep their old contents.
  always_comb begin
    line_d = line_q;
    for (int k = 0; k < NBEATS; k++) begin
      if (beat_fire_i && (beat_idx_i == IDX_W'(k))) begin
        line_d[k*BEAT_W +: BEAT_W] = beat_data_i;
      end
    end
  end

  // Critical-word forwarding fires once per refill, the cycle after its beat lands.
  always_comb begin
    crit_valid_d = crit_hit;
    crit_word_d  = crit_hit ? beat_data_i : crit_word_q;
    crit_done_d  = crit_done_q;
    if (start_i) begin
      crit_done_d = 1'b0;
    end else if (crit_hit) begin
      crit_done_d = 1'b1;
    end
  end

  // Line and critical-word registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      line_q       <= '0;
      crit_done_q  <= 1'b0;
      crit_valid_q <= 1'b0;
      crit_word_q  <= '0;
    end else begin
      line_q       <= line_d;
      crit_done_q  <= crit_done_d;
      crit_valid_q <= crit_valid_d;
      crit_word_q  <= crit_word_d;
    end
  end

  assign line_o       = line_q;
  assign crit_valid_o = crit_valid_q;
  assign crit_word_o  = crit_word_q;

endmodule

// File: rtl/icache_line_refill.sv
// rtl/icache_line_refill.sv - I-cache miss refill engine: burst read, line assembly, line store write
module icache_line_refill #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256,
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_valid,
  input  logic [ADDR_W-1:0] miss_addr,
  output logic              miss_ready,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [3:0]        mem_req_len,
  input  logic              mem_rdata_valid,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_rdata_last,
  input  logic              mem_rdata_err,
  output logic              mem_rdata_ready,
  output logic              line_enable,
  output logic              line_read,
  output logic              line_compare,
  output logic [ADDR_W-1:0] line_address,
  output logic [LINE_W-1:0] line_data,
  output logic              crit_valid,
  output logic [BEAT_W-1:0] crit_word,
  output logic              refill_done,
  output logic              refill_err,
  output logic              busy
);
  import icache_pkg::*;

  localparam int               NBEATS   = LINE_W / BEAT_W;
  localparam int               IDX_W    = $clog2(NBEATS);
  localparam int               TAG_W    = ADDR_W - OFFSET_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBEATS - 1);

  refill_state_e     state_q, state_d;
  logic [TAG_W-1:0]  line_addr_q, line_addr_d;
  logic [IDX_W-1:0]  crit_idx_q, crit_idx_d;
  logic [IDX_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic              miss_take;
  logic              beat_fire;
  logic              unused_miss_addr;

  // Byte-within-word bits only matter to the fetch stage, not to the refill.
  assign unused_miss_addr = ^miss_addr[OFFSET_W-IDX_W-1:0];

  assign miss_take = (state_q == IDLE) && miss_valid;
  assign beat_fire = (state_q == BEAT) && mem_rdata_valid;

  // Next-state and handshake outputs; idle defaults keep the line store in read mode.
  always_comb begin
    state_d         = state_q;
    miss_ready      = 1'b0;
    mem_req_valid   = 1'b0;
    mem_rdata_ready = 1'b0;
    line_enable     = 1'b0;
    line_read       = 1'b1;
    refill_done     = 1'b0;
    refill_err      = 1'b0;
    busy            = 1'b1;
    case (state_q)
      IDLE: begin
        miss_ready = 1'b1;
        busy       = 1'b0;
        if (miss_valid) state_d = REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = BEAT;
      end
      BEAT: begin
        mem_rdata_ready = 1'b1;
        if (mem_rdata_valid) begin
          if (mem_rdata_err) begin
            state_d = ERR;
          end else if (beat_cnt_q == LAST_IDX) begin
            state_d = mem_rdata_last ? FILL : ERR;
          end else if (mem_rdata_last) begin
            state_d = ERR;
          end
        end
      end
      FILL: begin
        line_enable = 1'b1;
        line_read   = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        refill_done = 1'b1;
        state_d     = IDLE;
      end
      ERR: begin
        refill_err = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Latch the request on acceptance and count beats as they land.
  always_comb begin
    line_addr_d = line_addr_q;
    crit_idx_d  = crit_idx_q;
    beat_cnt_d  = beat_cnt_q;
    if (miss_take) begin
      line_addr_d = miss_addr[ADDR_W-1:OFFSET_W];
      crit_idx_d  = miss_addr[OFFSET_W-1:OFFSET_W-IDX_W];
      beat_cnt_d  = '0;
    end else if (beat_fire) begin
      beat_cnt_d = beat_cnt_q + IDX_W'(1);
    end
  end

  // State and request registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      line_addr_q <= '0;
      crit_idx_q  <= '0;
      beat_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_addr_q <= line_addr_d;
      crit_idx_q  <= crit_idx_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  icache_line_assembler #(
    .LINE_W (LINE_W),
    .BEAT_W (BEAT_W),
    .IDX_W  (IDX_W)
  ) u_assembler (
    .clk          (clk),
    .rst          (rst),
    .start_i      (miss_take),
    .beat_fire_i  (beat_fire),
    .beat_err_i   (mem_rdata_err),
    .beat_idx_i   (beat_cnt_q),
    .beat_data_i  (mem_rdata),
    .crit_idx_i   (crit_idx_q),
    .line_o       (line_data),
    .crit_valid_o (crit_valid),
    .crit_word_o  (crit_word)
  );

  assign mem_req_addr = {line_addr_q, {OFFSET_W{1'b0}}};
  assign mem_req_len  = 4'(NBEATS - 1);
  assign line_address = {line_addr_q, {OFFSET_W{1'b0}}};
  assign line_compare = 1'b0;

endmodule

// File: tb/tb_icache_line_refill.sv
// tb/tb_icache_line_refill.sv - scoreboard bench for the I-cache line refill engine
module tb_icache_line_refill;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
  } line_exp_t;

  localparam int EV_DONE = 1;
  localparam int EV_ERR  = 2;

  logic         clk;
  logic         rst;
  logic         miss_valid;
  logic [31:0]  miss_addr;
  logic         miss_ready;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic [3:0]   mem_req_len;
  logic         mem_rdata_valid;
  logic [31:0]  mem_rdata;
  logic         mem_rdata_last;
  logic         mem_rdata_err;
  logic         mem_rdata_ready;
  logic         line_enable;
  logic         line_read;
  logic         line_compare;
  logic [31:0]  line_address;
  logic [255:0] line_data;
  logic         crit_valid;
  logic [31:0]  crit_word;
  logic         refill_done;
  logic         refill_err;
  logic         busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int req_count = 0;
  int line_count = 0;
  int crit_cyc = 0;
  int line_cyc = 0;
  int done_cyc = 0;

  logic [31:0] crit_q[$];
  int          ev_q[$];
  line_exp_t   line_q[$];

  icache_line_refill dut (
    .clk             (clk),
    .rst             (rst),
    .miss_valid      (miss_valid),
    .miss_addr       (miss_addr),
    .miss_ready      (miss_ready),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_req_len     (mem_req_len),
    .mem_rdata_valid (mem_rdata_valid),
    .mem_rdata       (mem_rdata),
    .mem_rdata_last  (mem_rdata_last),
    .mem_rdata_err   (mem_rdata_err),
    .mem_rdata_ready (mem_rdata_ready),
    .line_enable     (line_enable),
    .line_read       (line_read),
    .line_compare    (line_compare),
    .line_address    (line_address),
    .line_data       (line_data),
    .crit_valid      (crit_valid),
    .crit_word       (crit_word),
    .refill_done     (refill_done),
    .refill_err      (refill_err),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic monitor();
    logic [31:0] ew;
    line_exp_t   el;
    int          ev;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (mem_req_valid && mem_req_ready) req_count++;
        if (crit_valid) begin
          crit_cyc = cyc;
          checks++;
          if (crit_q.size() == 0) begin
            errors++;
            $display("FAIL crit_unexpected: got crit_word=%h, nothing expected", crit_word);
          end else begin
            ew = crit_q.pop_front();
            if (crit_word !== ew) begin
              errors++;
              $display("FAIL crit_word: got %h expected %h", crit_word, ew);
            end
          end
        end
        if (line_enable) begin
          line_cyc = cyc;
          line_count++;
          checks++;
          if (line_q.size() == 0) begin
            errors++;
            $display("FAIL line_unexpected: line write to %h, none expected", line_address);
          end else begin
            el = line_q.pop_front();
            if (line_address !== el.addr || line_data !== el.data ||
                line_read !== 1'b0 || line_compare !== 1'b0) begin
              errors++;
              $display("FAIL line_write: got addr=%h rd=%b cmp=%b data=%h expected addr=%h rd=0 cmp=0 data=%h",
                       line_address, line_read, line_compare, line_data, el.addr, el.data);
            end
          end
        end
        if (refill_done) begin
          done_cyc = cyc;
          checks++;
          if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL done_unexpected: refill_done with no outcome expected");
          end else begin
            ev = ev_q.pop_front();
            if (ev != EV_DONE) begin
              errors++;
              $display("FAIL done_outcome: got done expected outcome %0d (2=err)", ev);
            end
          end
        end
        if (refill_err) begin
          checks++;
          if (ev_q.size() == 0) begin
            errors++;
            $display("FAIL err_unexpected: refill_err with no outcome expected");
          end else begin
            ev = ev_q.pop_front();
            if (ev != EV_ERR) begin
              errors++;
              $display("FAIL err_outcome: got err expected outcome %0d (1=done)", ev);
            end
          end
        end
      end
    end
  endtask

  // last_beat: beat index carrying mem_rdata_last (-1 none); stop_beat: assert rst with that beat (-1 none)
  task automatic run_refill(input logic [31:0] addr, input int req_delay, input int gap,
                            input logic [31:0] base, input int err_beat, input int last_beat,
                            input int stop_beat, input bit hold_miss, output int req_cyc);
    logic [31:0]  la;
    logic [255:0] exp_line;
    line_exp_t    el;
    bit           aborted;
    bit           by_rst;
    int           budget;
    la       = {addr[31:5], 5'b0};
    exp_line = '0;
    aborted  = 1'b0;
    by_rst   = 1'b0;
    @(posedge clk); #1;
    miss_valid = 1'b1;
    miss_addr  = addr;
    @(posedge clk); #1;
    if (!hold_miss) begin
      miss_valid = 1'b0;
      miss_addr  = 32'hDEAD_BEEF;
    end
    for (int d = 0; d < req_delay; d++) begin
      @(negedge clk);
      checks++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== la || mem_req_len !== 4'd7) begin
        errors++;
        $display("FAIL req_wait: got valid=%b addr=%h len=%0d expected valid=1 addr=%h len=7",
                 mem_req_valid, mem_req_addr, mem_req_len, la);
      end
      @(posedge clk); #1;
    end
    mem_req_ready = 1'b1;
    @(negedge clk);
    req_cyc = cyc;
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== la || mem_req_len !== 4'd7) begin
      errors++;
      $display("FAIL req_handshake: got valid=%b addr=%h len=%0d expected valid=1 addr=%h len=7",
               mem_req_valid, mem_req_addr, mem_req_len, la);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    for (int k = 0; k < 8 && !aborted; k++) begin
      mem_rdata_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
      end
      mem_rdata_valid = 1'b1;
      mem_rdata       = base + 32'(k);
      mem_rdata_err   = (k == err_beat);
      mem_rdata_last  = (k == last_beat);
      if (k == stop_beat) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst     = 1'b0;
        aborted = 1'b1;
        by_rst  = 1'b1;
      end else begin
        exp_line[k*32 +: 32] = base + 32'(k);
        if (k == int'(addr[4:2]) && k != err_beat) crit_q.push_back(base + 32'(k));
        if (k == err_beat || (k < 7 && k == last_beat) || (k == 7 && last_beat != 7)) begin
          ev_q.push_back(EV_ERR);
          aborted = 1'b1;
        end else if (k == 7) begin
          el.addr = la;
          el.data = exp_line;
          line_q.push_back(el);
          ev_q.push_back(EV_DONE);
        end
        budget = 0;
        @(negedge clk);
        while (mem_rdata_ready !== 1'b1 && budget < 20) begin
          budget++;
          @(negedge clk);
        end
        if (budget >= 20) begin
          checks++;
          errors++;
          $display("FAIL beat_accept_timeout: beat %0d never accepted", k);
        end
        @(posedge clk); #1;
      end
    end
    mem_rdata_valid = 1'b0;
    mem_rdata_err   = 1'b0;
    mem_rdata_last  = 1'b0;
    if (!by_rst) begin
      budget = 0;
      @(negedge clk);
      while (refill_done !== 1'b1 && refill_err !== 1'b1 && budget < 40) begin
        budget++;
        @(negedge clk);
      end
      if (budget >= 40) begin
        checks++;
        errors++;
        $display("FAIL end_timeout: no refill_done/refill_err for addr %h", addr);
      end
      @(posedge clk); #1;
      miss_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    miss_valid      = 1'b0;
    miss_addr       = '0;
    mem_req_ready   = 1'b0;
    mem_rdata_valid = 1'b0;
    mem_rdata       = '0;
    mem_rdata_last  = 1'b0;
    mem_rdata_err   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b1 || busy !== 1'b0 || line_read !== 1'b1) begin
      errors++;
      $display("FAIL reset_ctrl: got miss_ready=%b busy=%b line_read=%b expected 1 0 1", miss_ready, busy, line_read);
    end
    checks++;
    if (mem_req_valid !== 1'b0 || mem_rdata_ready !== 1'b0 || line_enable !== 1'b0 || line_compare !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: got req_valid=%b rdata_ready=%b line_en=%b cmp=%b expected all 0",
               mem_req_valid, mem_rdata_ready, line_enable, line_compare);
    end
    checks++;
    if (crit_valid !== 1'b0 || refill_done !== 1'b0 || refill_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_pulses: got crit=%b done=%b err=%b expected 0 0 0", crit_valid, refill_done, refill_err);
    end
    checks++;
    if (line_data !== 256'h0 || crit_word !== 32'h0 || line_address !== 32'h0 || mem_req_addr !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got line=%h crit=%h laddr=%h raddr=%h expected zeros",
               line_data, crit_word, line_address, mem_req_addr);
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int rc;
    int lc;
    lc = line_count;
    run_refill(32'h0000_1234, 0, 0, 32'h0000_00A0, -1, 7, -1, 1'b0, rc);
    checks++;
    if (line_count != lc + 1) begin
      errors++;
      $display("FAIL basic_writes: got %0d line writes expected 1", line_count - lc);
    end
    checks++;
    if (crit_cyc - rc != 7 || line_cyc - rc != 9 || done_cyc - rc != 10) begin
      errors++;
      $display("FAIL basic_latency: got crit=+%0d line=+%0d done=+%0d expected +7 +9 +10",
               crit_cyc - rc, line_cyc - rc, done_cyc - rc);
    end
    checks++;
    if (line_data[191:160] !== 32'h0000_00A5 || crit_word !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL basic_crit_slot: got slot5=%h crit=%h expected a5 a5", line_data[191:160], crit_word);
    end
    @(negedge clk);
    checks++;
    if (miss_ready !== 1'b1 || cyc - rc != 11) begin
      errors++;
      $display("FAIL basic_ready_again: got miss_ready=%b at +%0d expected 1 at +11", miss_ready, cyc - rc);
    end
  endtask

  task automatic test_gaps();
    int rc;
    int lc;
    lc = line_count;
    run_refill(32'h0000_1234, 3, 2, 32'h0000_00A0, -1, 7, -1, 1'b0, rc);
    checks++;
    if (line_count != lc + 1 || line_cyc - rc != 25 || done_cyc - rc != 26) begin
      errors++;
      $display("FAIL gaps_timing: got writes=%0d line=+%0d done=+%0d expected 1 +25 +26",
               line_count - lc, line_cyc - rc, done_cyc - rc);
    end
    checks++;
    if (line_data[191:160] !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL gaps_slot5: got %h expected a5", line_data[191:160]);
    end
  endtask

  task automatic test_err_beat();
    int rc;
    int lc;
    lc = line_count;
    run_refill(32'h0000_1234, 0, 0, 32'h0000_00B0, 3, 7, -1, 1'b0, rc);
    @(negedge clk);
    checks++;
    if (line_count != lc || miss_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_beat: got writes=%0d miss_ready=%b busy=%b expected 0 1 0",
               line_count - lc, miss_ready, busy);
    end
  endtask

  task automatic test_protocol_err();
    int rc;
    int lc;
    lc = line_count;
    run_refill(32'h0000_4000, 0, 0, 32'h0000_0C00, -1, 5, -1, 1'b0, rc);
    checks++;
    if (line_count != lc) begin
      errors++;
      $display("FAIL early_last: got %0d line writes expected 0", line_count - lc);
    end
    run_refill(32'h0000_4008, 0, 0, 32'h0000_0C10, -1, -1, -1, 1'b0, rc);
    @(negedge clk);
    checks++;
    if (line_count != lc || miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL missing_last: got writes=%0d miss_ready=%b expected 0 1", line_count - lc, miss_ready);
    end
  endtask

  task automatic test_rst_mid();
    int rc;
    int lc;
    lc = line_count;
    run_refill(32'h0000_5014, 0, 0, 32'h0000_00C0, -1, 7, 4, 1'b0, rc);
    mem_rdata_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || miss_ready !== 1'b1 || mem_rdata_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_idle: got busy=%b miss_ready=%b rdata_ready=%b expected 0 1 0",
               busy, miss_ready, mem_rdata_ready);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (line_count != lc || ev_q.size() != 0 || crit_q.size() != 0) begin
      errors++;
      $display("FAIL rst_quiet: got writes=%0d pending_ev=%0d pending_crit=%0d expected 0 0 0",
               line_count - lc, ev_q.size(), crit_q.size());
    end
    run_refill(32'h0000_5014, 0, 0, 32'h0000_00D0, -1, 7, -1, 1'b0, rc);
    checks++;
    if (line_count != lc + 1 || line_data[191:160] !== 32'h0000_00D5) begin
      errors++;
      $display("FAIL rst_recover: got writes=%0d slot5=%h expected 1 d5", line_count - lc, line_data[191:160]);
    end
  endtask

  task automatic test_back_to_back();
    int rc;
    int rq;
    rq = req_count;
    run_refill(32'h0000_2000, 0, 0, 32'h0000_00E0, -1, 7, -1, 1'b1, rc);
    repeat (3) @(negedge clk);
    checks++;
    if (req_count != rq + 1 || crit_cyc - rc != 2 || miss_ready !== 1'b1) begin
      errors++;
      $display("FAIL held_off0: got reqs=%0d crit=+%0d miss_ready=%b expected 1 +2 1",
               req_count - rq, crit_cyc - rc, miss_ready);
    end
    rq = req_count;
    run_refill(32'h0000_301C, 0, 0, 32'h0000_00F0, -1, 7, -1, 1'b1, rc);
    repeat (3) @(negedge clk);
    checks++;
    if (req_count != rq + 1 || crit_cyc - rc != 9 || crit_word !== 32'h0000_00F7) begin
      errors++;
      $display("FAIL held_off1c: got reqs=%0d crit=+%0d word=%h expected 1 +9 f7",
               req_count - rq, crit_cyc - rc, crit_word);
    end
  endtask

  initial begin
    rst = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_gaps();
    test_err_beat();
    test_protocol_err();
    test_rst_mid();
    test_back_to_back();
    repeat (3) @(negedge clk);
    checks++;
    if (crit_q.size() != 0 || ev_q.size() != 0 || line_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending crit=%0d ev=%0d line=%0d expected 0 0 0",
               crit_q.size(), ev_q.size(), line_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
